// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared constants, state type and address helpers for the HD44780 bus responder.
package lcd_hd44780_responder_pkg;

  localparam logic [7:0] CmdClear = 8'h01;
  localparam logic [7:0] CmdHome  = 8'h02;
  localparam logic [7:0] CmdEntry = 8'h04;
  localparam logic [7:0] CmdDisp  = 8'h08;
  localparam logic [7:0] CmdShift = 8'h10;
  localparam logic [7:0] CmdFunc  = 8'h20;
  localparam logic [7:0] CmdCgram = 8'h40;
  localparam logic [7:0] CmdDdram = 8'h80;

  localparam logic [6:0] Line0Base = 7'h00;
  localparam logic [6:0] Line1Base = 7'h40;
  localparam logic [6:0] LineLen   = 7'd16;
  localparam logic [6:0] LineSpan  = 7'd40;
  localparam int unsigned NumCells = 32;
  localparam logic [7:0] BlankChar = 8'h20;

  typedef enum logic [1:0] {StIdle, StAccess, StExec} bus_state_e;

  // Only the first 16 columns of each DDRAM line are backed by cells.
  function automatic logic ac_valid(logic [6:0] ac);
    return ((ac - Line0Base) < LineLen) || ((ac - Line1Base) < LineLen);
  endfunction

  function automatic logic [4:0] cell_idx(logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// LCD parallel bus as seen between the initiator (master) and this responder (slave).
interface lcd_hd44780_responder_if;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA_IN;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE;

  modport master (
    output LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
    input  LCD_DATA_OUT, LCD_DATA_OE
  );

  modport slave (
    input  LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
    output LCD_DATA_OUT, LCD_DATA_OE
  );
endinterface

// File: rtl/lcd_ac_step.sv
// Next address-counter value for one cursor step with 2-line DDRAM wrap.
module lcd_ac_step
  import lcd_hd44780_responder_pkg::*;
(
  input  logic [6:0] ac,
  input  logic       inc,
  output logic [6:0] ac_next
);
  localparam logic [6:0] Line0Last = Line0Base + LineSpan - 7'd1;
  localparam logic [6:0] Line1Last = Line1Base + LineSpan - 7'd1;

  always_comb begin
    ac_next = ac;
    if (inc) begin
      if (ac == Line0Last)      ac_next = Line1Base;
      else if (ac == Line1Last) ac_next = Line0Base;
      else                      ac_next = ac + 7'd1;
    end else begin
      if (ac == Line1Base)      ac_next = Line0Last;
      else if (ac == Line0Base) ac_next = Line1Last;
      else                      ac_next = ac - 7'd1;
    end
  end
endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-style bus responder: decodes commands and data into a 2x16 character store.
module lcd_hd44780_responder
  import lcd_hd44780_responder_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 80000
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  lcd_hd44780_responder_if.slave   lcd,
  input  logic [4:0]               iRD_ADDR,
  output logic [7:0]               oRD_CHAR,
  output logic                     oBUSY,
  output logic                     oDISP_ON,
  output logic                     oFUNC_OK,
  output logic                     oOVERRUN
);
  localparam int unsigned CntW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CntW-1:0] BusyLoad  = CntW'(BUSY_CYCLES);
  localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYCLES);

  logic en_s1_q, en_s2_q, en_s3_q;
  logic rise, fall;
  bus_state_e state_q, state_d;
  logic rs_q, rw_q;
  logic [7:0] din_q;
  logic drive, exec;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0] ac_q, ac_d, ac_stepped;
  logic id_q, id_d, disp_q, disp_d, func_q, func_d, ovr_q, ovr_d;
  logic fill_q, fill_d;
  logic [4:0] fill_idx_q, fill_idx_d;
  logic [7:0] cells_q [NumCells];
  logic [7:0] rd_char_q;
  logic bf, status_rd, accept, write_en, step_inc;
  logic [7:0] ac_char;

  assign rise = en_s2_q & ~en_s3_q;
  assign fall = ~en_s2_q & en_s3_q;
  assign bf   = (cnt_q != '0);

  // State register plus bus capture.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= StIdle;
      {en_s1_q, en_s2_q, en_s3_q} <= 3'b000;
      rs_q  <= 1'b0;
      rw_q  <= 1'b0;
      din_q <= 8'h00;
    end else begin
      state_q <= state_d;
      {en_s1_q, en_s2_q, en_s3_q} <= {lcd.LCD_EN, en_s1_q, en_s2_q};
      if (rise && state_q != StAccess) {rs_q, rw_q} <= {lcd.LCD_RS, lcd.LCD_RW};
      if (fall && state_q == StAccess) din_q <= lcd.LCD_DATA_IN;
    end
  end

  // A fall seen in StIdle has no matching rise and is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rise) state_d = StAccess;
      StAccess: if (fall) state_d = StExec;
      StExec:   state_d = rise ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    drive = (state_q == StAccess) && rw_q;
    exec  = (state_q == StExec);
  end

  assign ac_char          = ac_valid(ac_q) ? cells_q[cell_idx(ac_q)] : BlankChar;
  assign lcd.LCD_DATA_OE  = drive;
  assign lcd.LCD_DATA_OUT = drive ? (rs_q ? ac_char : {bf, ac_q}) : 8'h00;

  assign status_rd = !rs_q && rw_q;
  assign accept    = exec && !status_rd && !bf;
  assign write_en  = accept && rs_q && !rw_q && ac_valid(ac_q);
  assign step_inc  = (!rs_q && din_q[7:4] == 4'h1) ? din_q[2] : id_q;

  lcd_ac_step u_ac_step (
    .ac      (ac_q),
    .inc     (step_inc),
    .ac_next (ac_stepped)
  );

  always_comb begin
    cnt_d      = bf ? cnt_q - CntW'(1) : cnt_q;
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    func_d     = func_q;
    ovr_d      = ovr_q | (exec && !status_rd && bf);
    fill_d     = fill_q && (fill_idx_q != 5'd31);
    fill_idx_d = fill_q ? fill_idx_q + 5'd1 : fill_idx_q;
    if (accept) begin
      cnt_d = BusyLoad;
      if (rs_q) begin
        ac_d = ac_stepped;
      end else if (|(din_q & CmdDdram)) begin
        ac_d = din_q[6:0];
      end else if (|(din_q & CmdCgram)) begin
        ac_d = ac_q;
      end else if (|(din_q & CmdFunc)) begin
        func_d = din_q[4] & din_q[3];
      end else if (|(din_q & CmdShift)) begin
        if (!din_q[3]) ac_d = ac_stepped;
      end else if (|(din_q & CmdDisp)) begin
        disp_d = din_q[2];
      end else if (|(din_q & CmdEntry)) begin
        id_d = din_q[1];
      end else if (|(din_q & CmdHome)) begin
        ac_d  = Line0Base;
        cnt_d = ClearLoad;
      end else if (|(din_q & CmdClear)) begin
        ac_d       = Line0Base;
        id_d       = 1'b1;
        cnt_d      = ClearLoad;
        fill_d     = 1'b1;
        fill_idx_d = 5'd0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cnt_q      <= '0;
      ac_q       <= Line0Base;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      func_q     <= 1'b0;
      ovr_q      <= 1'b0;
      fill_q     <= 1'b0;
      fill_idx_q <= 5'd0;
      rd_char_q  <= 8'h00;
      for (int i = 0; i < NumCells; i++) cells_q[i] <= BlankChar;
    end else begin
      cnt_q      <= cnt_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      func_q     <= func_d;
      ovr_q      <= ovr_d;
      fill_q     <= fill_d;
      fill_idx_q <= fill_idx_d;
      rd_char_q  <= cells_q[iRD_ADDR];
      if (fill_q)   cells_q[fill_idx_q]     <= BlankChar;
      if (write_en) cells_q[cell_idx(ac_q)] <= din_q;
    end
  end

  assign oRD_CHAR = rd_char_q;
  assign oBUSY    = bf;
  assign oDISP_ON = disp_q;
  assign oFUNC_OK = func_q;
  assign oOVERRUN = ovr_q;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Randomized bench for lcd_hd44780_responder against a linear-cursor display model.
module tb_lcd_hd44780_responder;
  localparam int unsigned BusyCyc  = 20;
  localparam int unsigned ClearCyc = 64;

  logic       clk;
  logic       rst_n;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       busy, disp_on, func_ok, overrun;

  lcd_hd44780_responder_if lcd_bus ();

  lcd_hd44780_responder #(
    .BUSY_CYCLES  (BusyCyc),
    .CLEAR_CYCLES (ClearCyc)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .lcd      (lcd_bus),
    .iRD_ADDR (rd_addr),
    .oRD_CHAR (rd_char),
    .oBUSY    (busy),
    .oDISP_ON (disp_on),
    .oFUNC_OK (func_ok),
    .oOVERRUN (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: cursor is a linear position 0..79 over two 40-column lines.
  logic [7:0] m_cells [32];
  int m_pos;
  bit m_id;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ac_of(input int p);
    return (p / 40) * 64 + (p % 40);
  endfunction

  function automatic int step_pos(input int p, input bit up);
    return up ? (p + 1) % 80 : (p + 79) % 80;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_pos = 0;
    m_id  = 1'b1;
  endtask

  task automatic m_cmd(input logic [7:0] c);
    int a;
    if (c >= 8'h80) begin
      a = int'(c) - 128;
      m_pos = (a >= 64 ? 40 : 0) + (a % 64);
    end else if (c >= 8'h40) begin
    end else if (c >= 8'h20) begin
    end else if (c >= 8'h10) begin
      if (((c / 8) % 2) == 0) m_pos = step_pos(m_pos, ((c / 4) % 2) == 1);
    end else if (c >= 8'h08) begin
    end else if (c >= 8'h04) begin
      m_id = ((c / 2) % 2) == 1;
    end else if (c >= 8'h02) begin
      m_pos = 0;
    end else if (c == 8'h01) begin
      for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
      m_pos = 0;
      m_id  = 1'b1;
    end
  endtask

  function automatic logic [7:0] m_char_at_cursor();
    int col;
    col = m_pos % 40;
    return (col < 16) ? m_cells[(m_pos / 40) * 16 + col] : 8'h20;
  endfunction

  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] din,
                          output logic [7:0] dout, output logic oe);
    @(negedge clk);
    lcd_bus.LCD_RS      = rs;
    lcd_bus.LCD_RW      = rw;
    lcd_bus.LCD_DATA_IN = din;
    lcd_bus.LCD_EN      = 1'b1;
    repeat (6) @(negedge clk);
    dout = lcd_bus.LCD_DATA_OUT;
    oe   = lcd_bus.LCD_DATA_OE;
    lcd_bus.LCD_EN = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy && n < 4 * ClearCyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("bf_clears", busy, 1'b0);
  endtask

  task automatic do_cmd(input logic [7:0] c);
    logic [7:0] d;
    logic oe;
    bus_xfer(1'b0, 1'b0, c, d, oe);
    m_cmd(c);
    wait_ready();
  endtask

  task automatic do_write(input logic [7:0] c);
    logic [7:0] d;
    logic oe;
    int col;
    bus_xfer(1'b1, 1'b0, c, d, oe);
    col = m_pos % 40;
    if (col < 16) m_cells[(m_pos / 40) * 16 + col] = c;
    m_pos = step_pos(m_pos, m_id);
    wait_ready();
  endtask

  task automatic do_read();
    logic [7:0] d;
    logic oe;
    bus_xfer(1'b1, 1'b1, 8'h00, d, oe);
    check_eq("read_oe", oe, 1'b1);
    check_eq("read_data", d, m_char_at_cursor());
    m_pos = step_pos(m_pos, m_id);
    wait_ready();
  endtask

  task automatic check_status();
    logic [7:0] d, e;
    logic oe;
    bus_xfer(1'b0, 1'b1, 8'h00, d, oe);
    e = 8'(ac_of(m_pos));
    check_eq("status_oe", oe, 1'b1);
    check_eq("status", d, e);
  endtask

  task automatic check_cell(input int i, input logic [7:0] exp);
    rd_addr = 5'(i);
    @(negedge clk);
    check_eq($sformatf("cell%0d", i), rd_char, exp);
  endtask

  task automatic check_all_cells();
    for (int i = 0; i < 32; i++) check_cell(i, m_cells[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_disp"}, disp_on, 1'b0);
    check_eq({tag, "_func"}, func_ok, 1'b0);
    check_eq({tag, "_ovr"}, overrun, 1'b0);
    check_eq({tag, "_oe"}, lcd_bus.LCD_DATA_OE, 1'b0);
    check_eq({tag, "_dout"}, lcd_bus.LCD_DATA_OUT, 8'h00);
    check_eq({tag, "_rdchar"}, rd_char, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    logic oe;
    int bf_len;
    int op;
    logic [7:0] str [3];
    str[0] = 8'h46; str[1] = 8'h4C; str[2] = 8'h41;

    rst_n = 1'b0;
    rd_addr = 5'd0;
    lcd_bus.LCD_EN = 1'b0;
    lcd_bus.LCD_RS = 1'b0;
    lcd_bus.LCD_RW = 1'b0;
    lcd_bus.LCD_DATA_IN = 8'h00;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Init sequence.
    do_cmd(8'h38);
    do_cmd(8'h0C);
    do_cmd(8'h01);
    do_cmd(8'h06);
    do_cmd(8'h80);
    check_eq("func_ok", func_ok, 1'b1);
    check_eq("disp_on", disp_on, 1'b1);
    check_status();
    check_all_cells();

    for (int i = 0; i < 3; i++) do_write(str[i]);
    for (int i = 0; i < 3; i++) check_cell(i, str[i]);
    check_status();

    // Fill line 1, then one write past the visible columns.
    do_cmd(8'hC0);
    for (int i = 0; i < 16; i++) do_write(8'($urandom_range(8'h21, 8'h7E)));
    check_all_cells();
    check_status();
    do_write(8'h2A);
    check_all_cells();

    // Wrap checks.
    do_cmd(8'hA7);
    do_write(8'h31);
    check_status();
    do_cmd(8'h80);
    do_cmd(8'h04);
    do_write(8'h32);
    check_status();
    check_cell(0, 8'h32);

    // Write arriving during the clear busy window.
    fork
      begin
        int n, g;
        n = 0;
        g = 0;
        while (!busy && g < 200) begin
          @(negedge clk);
          g++;
        end
        while (busy && n < 4 * ClearCyc) begin
          n++;
          @(negedge clk);
        end
        bf_len = n;
      end
      begin
        bus_xfer(1'b0, 1'b0, 8'h01, d, oe);
        bus_xfer(1'b1, 1'b0, 8'h58, d, oe);
      end
    join
    m_cmd(8'h01);
    check_eq("clear_bf_len", bf_len, ClearCyc);
    check_eq("overrun", overrun, 1'b1);
    wait_ready();
    check_status();
    check_all_cells();

    // Randomized mix of operations.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: do_cmd(8'h80 | 8'($urandom_range(0, 1) * 64 + $urandom_range(0, 39)));
        1: do_cmd(8'h04 | 8'($urandom_range(0, 1) * 2));
        2: do_write(8'($urandom_range(8'h21, 8'h7E)));
        3: do_read();
        default: do_cmd(8'h10 | 8'($urandom_range(0, 1) * 4));
      endcase
      check_status();
    end
    check_all_cells();

    // Reset in the middle of a clear fill.
    do_cmd(8'hCF);
    do_write(8'h5A);
    check_cell(31, 8'h5A);
    bus_xfer(1'b0, 1'b0, 8'h01, d, oe);
    check_cell(31, 8'h5A);
    check_cell(0, 8'h20);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midclr");
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    check_cell(31, 8'h20);
    do_cmd(8'h80);
    do_write(8'h41);
    check_cell(0, 8'h41);
    check_status();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
